cla_byte_sequencer: RTL and testbench

- Multi-cycle add/subtract controller for WIDTH-bit operands (FP mantissa/exponent paths).
- Time-shares one external 8-bit carry-lookahead adder slice, one byte per cycle, LSB first, chaining carry between cycles.
- Sits between the FP ALU control and the single adder instance; valid/ready handshake on both request and result sides.
- Also produces carry, signed-overflow and zero flags.

---
 rtl/cla_byte_sequencer.sv | 169 ++++++++++++++++
 tb/tb_cla_byte_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_byte_sequencer.sv
// cla_byte_sequencer: multi-cycle WIDTH-bit add/subtract built on one external
// 8-bit adder slice. One byte is processed per cycle, LSB first. The carry is
// chained through a register between cycles. Carry, signed-overflow and zero
// flags are produced alongside the result.
module cla_byte_sequencer #(
    parameter  int WIDTH  = 24,
    localparam int SLICES = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [7:0]       adder_a,
    output logic [7:0]       adder_b,
    output logic             adder_cin,
    input  logic [7:0]       adder_s,
    input  logic             adder_cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int IDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);
    // Bytes below the top one; they are already written when the top byte lands.
    localparam logic [WIDTH-1:0] LOW_MASK = (WIDTH'(1) << (WIDTH - 8)) - WIDTH'(1);

    generate
        if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
            $error("cla_byte_sequencer: WIDTH must be a multiple of 8 and at least 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic               r_carry;
    logic               r_sign_a;
    logic               r_sign_b;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry_out;
    logic               r_overflow;
    logic               r_zero;
    logic [WIDTH-1:0]   w_b_eff;
    logic               w_last;

    // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
    assign w_b_eff = op_sub ? ~b_in : b_in;
    assign w_last  = (r_idx == LAST_IDX);

    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;
    assign zero      = r_zero;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic, handshake outputs and adder-slice drive.
    always_comb begin
        w_state_next = r_state;
        start_ready  = 1'b0;
        res_valid    = 1'b0;
        adder_a      = 8'h00;
        adder_b      = 8'h00;
        adder_cin    = 1'b0;
        case (r_state)
            S_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                adder_a   = r_op_a[{r_idx, 3'b000} +: 8];
                adder_b   = r_op_b[{r_idx, 3'b000} +: 8];
                adder_cin = r_carry;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operand capture, byte index, carry chain and final flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_carry     <= 1'b0;
            r_sign_a    <= 1'b0;
            r_sign_b    <= 1'b0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        r_op_a   <= a_in;
                        r_op_b   <= w_b_eff;
                        r_carry  <= op_sub;
                        r_idx    <= '0;
                        r_sign_a <= a_in[WIDTH-1];
                        r_sign_b <= w_b_eff[WIDTH-1];
                    end
                end
                S_RUN: begin
                    r_carry <= adder_cout;
                    if (w_last) begin
                        r_idx       <= '0;
                        r_carry_out <= adder_cout;
                        r_overflow  <= (r_sign_a == r_sign_b) && (adder_s[7] != r_sign_a);
                        r_zero      <= ((r_result & LOW_MASK) == '0) && (adder_s == 8'h00);
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // One register byte per slice; each byte loads the adder sum on its own pass.
    genvar gi;
    generate
        for (gi = 0; gi < SLICES; gi++) begin : g_res_byte
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_result[8*gi +: 8] <= 8'h00;
                end else if (r_state == S_RUN && r_idx == IDX_W'(gi)) begin
                    r_result[8*gi +: 8] <= adder_s;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_cla_byte_sequencer.sv
// Testbench for cla_byte_sequencer. It models the external 8-bit adder slice.
// The driver pushes the expected response into a scoreboard when a request is
// accepted. A separate monitor pops and compares that entry at each result
// handshake.
module tb_cla_byte_sequencer;

    localparam int W      = 24;
    localparam int SLICES = W / 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] res;
        logic         c;
        logic         v;
        logic         z;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic         op_sub = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic [7:0]   adder_a;
    logic [7:0]   adder_b;
    logic         adder_cin;
    logic [7:0]   adder_s;
    logic         adder_cout;
    logic         res_valid;
    logic         res_ready = 1'b1;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         zero;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   last_acc = 0;
    int   n_txn    = 0;
    logic prev_valid = 1'b0;
    exp_t sb_q[$];

    cla_byte_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_sub      (op_sub),
        .a_in        (a_in),
        .b_in        (b_in),
        .adder_a     (adder_a),
        .adder_b     (adder_b),
        .adder_cin   (adder_cin),
        .adder_s     (adder_s),
        .adder_cout  (adder_cout),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .carry_out   (carry_out),
        .overflow    (overflow),
        .zero        (zero)
    );

    // External 8-bit adder slice.
    assign {adder_cout, adder_s} = {1'b0, adder_a} + {1'b0, adder_b} + {8'h00, adder_cin};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got time limit expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: whole-word arithmetic on integers.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        exp_t   e;
        longint m  = longint'(1) << W;
        longint h  = m / 2;
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = a[W-1] ? ua - m : ua;
        longint sb = b[W-1] ? ub - m : ub;
        longint r;
        longint s;
        if (sub) begin
            r   = ua - ub;
            s   = sa - sb;
            e.c = (ua >= ub);
        end else begin
            r   = ua + ub;
            s   = sa + sb;
            e.c = (r >= m);
        end
        e.res = W'(r & (m - 1));
        e.v   = (s >= h) || (s < -h);
        e.z   = (e.res == '0);
        e.a   = a;
        e.b   = b;
        e.sub = sub;
        e.acc = 0;
        return e;
    endfunction

    // Expected {adder_a, adder_b, adder_cin} on byte pass i, from the carry into bit 8*i.
    function automatic longint bus_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic sub, input int i);
        logic [W-1:0] be   = sub ? ~b : b;
        longint       ua   = longint'(a);
        longint       ub   = longint'(be);
        longint       mask = (longint'(1) << (8 * i)) - 1;
        longint       cin  = (((ua & mask) + (ub & mask) + longint'(sub)) >> (8 * i)) & 1;
        return (((ua >> (8 * i)) & 255) << 9) | (((ub >> (8 * i)) & 255) << 1) | cin;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return W'(1);
            2:       return {1'b0, {(W-1){1'b1}}};
            3:       return {1'b1, {(W-1){1'b0}}};
            4:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    // Called at a negedge. Presents a request until accepted and pushes the
    // expectation. Then checks the adder bus on the next bus_cycles negedges.
    task automatic do_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input int bus_cycles, output int waited);
        exp_t e;
        start_valid = 1'b1;
        a_in        = a;
        b_in        = b;
        op_sub      = sub;
        waited      = 0;
        while (!start_ready && waited <= 100) begin
            @(negedge clk);
            waited++;
        end
        if (!start_ready) begin
            chk_eq("accept_timeout", longint'(start_ready), 1);
            start_valid = 1'b0;
            return;
        end
        e        = model(a, b, sub);
        e.acc    = cyc + 1;
        last_acc = e.acc;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        a_in        = W'($urandom);
        b_in        = W'($urandom);
        op_sub      = 1'($urandom);
        for (int i = 0; i < bus_cycles; i++) begin
            @(negedge clk);
            chk_eq("adder_bus", longint'({adder_a, adder_b, adder_cin}), bus_exp(a, b, sub, i));
        end
    endtask

    // Monitor: latency on each res_valid rise, scoreboard compare on each handshake.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (res_valid && !prev_valid) begin
                chk_eq("latency", (sb_q.size() == 0) ? -1 : longint'(cyc + 1 - sb_q[0].acc),
                       SLICES + 1);
            end
            if (res_valid && res_ready) begin
                chk_eq("sb_pending", longint'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk_eq("result_flags", longint'({result, carry_out, overflow, zero}),
                           longint'({e.res, e.c, e.v, e.z}));
                    $display("txn %0d: a=%h b=%h sub=%0d -> res=%h c=%0d v=%0d z=%0d",
                             n_txn, e.a, e.b, e.sub, result, carry_out, overflow, zero);
                    n_txn++;
                end
            end
            prev_valid = res_valid;
        end
    end

    initial begin
        int   w;
        int   prev;
        exp_t bp;

        // Reset values.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_eq("rst_start_ready", longint'(start_ready), 1);
        chk_eq("rst_res_valid", longint'(res_valid), 0);
        chk_eq("rst_result_flags", longint'({result, carry_out, overflow, zero}), 0);
        chk_eq("rst_adder_bus", longint'({adder_a, adder_b, adder_cin}), 0);

        // Directed cases: carry ripple, borrow, signed overflow, wrap to zero.
        do_req(24'h00FFFF, 24'h000001, 1'b0, SLICES, w);
        do_req(24'h000005, 24'h000007, 1'b1, SLICES, w);
        do_req(24'h7FFFFF, 24'h000001, 1'b0, SLICES, w);
        do_req(24'hFFFFFF, 24'h000001, 1'b0, SLICES, w);
        @(negedge clk);
        chk_eq("idle_adder_bus", longint'({adder_a, adder_b, adder_cin}), 0);

        // Backpressure: result held while res_ready is low; new request waits.
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        bp = model(24'h00ABCD, 24'h001234, 1'b1);
        do_req(24'h00ABCD, 24'h001234, 1'b1, SLICES, w);
        @(negedge clk);
        start_valid = 1'b1;
        a_in        = 24'h000777;
        b_in        = 24'h000111;
        op_sub      = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk_eq("bp_hold", longint'({res_valid, start_ready, result, carry_out, overflow, zero}),
                   longint'({1'b1, 1'b0, bp.res, bp.c, bp.v, bp.z}));
            @(negedge clk);
        end
        @(posedge clk);
        #1 res_ready = 1'b1;
        @(negedge clk);
        do_req(24'h000777, 24'h000111, 1'b0, SLICES, w);
        chk_eq("bp_accept_wait", w, 1);

        // Reset during the second RUN cycle discards the operation.
        do_req(24'h123456, 24'h111111, 1'b0, 1, w);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        sb_q.delete();
        chk_eq("midrst_start_ready", longint'(start_ready), 1);
        chk_eq("midrst_res_valid", longint'(res_valid), 0);
        chk_eq("midrst_result", longint'({result, carry_out, overflow, zero}), 0);
        for (int k = 0; k < SLICES + 2; k++) begin
            @(negedge clk);
            chk_eq("midrst_no_valid", longint'(res_valid), 0);
        end
        do_req(24'h000001, 24'h000002, 1'b0, SLICES, w);

        // Back-to-back random traffic with res_ready tied high.
        for (int n = 0; n < 1000; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra   = pick();
            rb   = pick();
            prev = last_acc;
            do_req(ra, rb, 1'($urandom), SLICES, w);
            chk_eq("spacing", last_acc - prev, SLICES + 2);
        end

        // Drain the scoreboard.
        for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(negedge clk);
        chk_eq("drain", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
